umi_fifo_flex_arb: RTL and testbench
====================================

# umi_fifo_flex_arb

Round-robin, message-aware arbiter that shares one UMI input port of a `umi_fifo_flex` among N requesters. It sits directly in front of the FIFO's `umi_in_*` port and adds one output register stage. It locks the grant for the whole multi-transaction message, so that message is never interleaved with traffic from other requesters.

## Interface
Parameters:
- N, 4, number of requesters (1..16)
- DW, 256, UMI data width (matches the FIFO's IDW)
- AW, 64, UMI address width
- CW, 32, UMI command width

Ports:
- clk  input  1  single clock for all logic
- nreset  input  1  asynchronous, active-low reset
- umi_in_valid  input  N  per-requester valid
- umi_in_cmd  input  N*CW  requester i at [i*CW +: CW]
- umi_in_dstaddr  input  N*AW  packed like cmd
- umi_in_srcaddr  input  N*AW  packed like cmd
- umi_in_data  input  N*DW  packed like cmd
- umi_in_ready  output  N  per-requester ready
- umi_in_mask  input  N  1 = requester excluded from new arbitration
- umi_out_valid  output  1  to FIFO `umi_in_valid`
- umi_out_cmd/dstaddr/srcaddr/data  output  CW/AW/AW/DW  registered payload
- umi_out_ready  input  1  from FIFO `umi_in_ready`
- grant  output  N  one-hot current grant, or 0 when no grant
- locked  output  1  1 while inside a message

## Operation
- Beat = one valid&ready handshake. The EOM bit is cmd[22]; message end is an accepted beat with EOM=1.
- The output stage is a single register, `out_full` (= umi_out_valid).
  - `load` = accepted input beat.
  - `space` = ~out_full | umi_out_ready.
- State machine:
  - IDLE: no lock. Candidates = umi_in_valid & ~umi_in_mask.
    - Grant goes to the first candidate at or after rr_ptr, wrapping modulo N. The grant is combinational from the candidates.
    - umi_in_ready[g] = space; every other ready bit = 0.
    - Accepted beat with EOM=0 -> LOCKED, lock_id = g.
    - Accepted beat with EOM=1 -> stay in IDLE, rr_ptr = (g+1) mod N.
  - LOCKED: grant = lock_id regardless of mask or other valids. umi_in_ready[lock_id] = space.
    - Accepted beat with EOM=1 -> IDLE, rr_ptr = (lock_id+1) mod N.
    - Accepted beat with EOM=0 -> stay in LOCKED.
- rr_ptr is clog2(N) bits. The wrap from N-1 to 0 is explicit and does not rely on a power of two.
- Output register, evaluated every cycle:
  - If load: payload ← selected requester, out_full ← 1.
  - Else if umi_out_ready: out_full ← 0.
  - Otherwise hold; the payload is unchanged while out_full=1 and umi_out_ready=0.
- grant is 0 in IDLE when there are no candidates. Masked requesters see ready=0 in IDLE.
- Deasserting umi_in_mask on the locked requester mid-message has no effect until the message ends.
- N=1: rr_ptr stays 0, and the lock logic still tracks EOM.

## Timing
- Reset values: umi_out_valid=0, umi_in_ready=0, grant=0, locked=0, rr_ptr=0, state=IDLE. umi_out payload registers reset to 0.
- Latency: an input beat accepted in cycle t appears on umi_out_* in cycle t+1.
- Throughput: 1 beat/cycle while umi_out_ready=1.
- Backpressure: with out_full=1 and umi_out_ready=0, all umi_in_ready are 0 (no skid entry).
- umi_in_ready depends combinationally on umi_out_ready. This is the only input-to-output combinational path besides grant.
- Simultaneous in the same cycle: out drain plus new load -> out_full stays 1 and the payload is replaced with no bubble.
- Simultaneous in the same cycle: EOM accept plus new requests -> the new arbitration uses the updated rr_ptr from the next cycle.
- nreset asserted mid-message: the lock drops, out_valid drops immediately (asynchronously), and the partial message is discarded by design. Upstream must resend.

## Test plan
- Reset: hold nreset=0 with all valid=1 -> umi_out_valid=0, umi_in_ready=0, grant=0. First grant after release goes to requester 0.
- Fairness:
  - Stimulus: N=4, all requesters send continuous single-beat messages (EOM=1), umi_out_ready=1.
  - Required response: output order is 0,1,2,3,0,1… with 1 beat/cycle and first output one cycle after first accept.
- Message lock:
  - Stimulus: requester 2 sends 3 beats with EOM=0,0,1; requesters 0 and 3 are valid throughout.
  - Required response: 3 consecutive outputs from requester 2 with locked=1 for the first two accepts; the next grant goes to requester 3.
- Backpressure:
  - Stimulus: umi_out_ready=0 for 5 cycles with a beat held in the output register.
  - Required response: the payload is stable, all umi_in_ready=0, and no beat is lost or duplicated once ready returns.
- Mask:
  - Stimulus: umi_in_mask=4'b0010 with all requesters valid.
  - Required response: requester 1 is never granted.
  - Stimulus: set the mask bit of requester 1 mid-message while requester 1 is locked.
  - Required response: the message still completes.
- Reset mid-message:
  - Stimulus: assert nreset after beat 1 of a 3-beat message.
  - Required response: locked=0 and out_valid=0 immediately; after release, rr_ptr=0 and arbitration restarts at requester 0.

Source files
------------

// File: rtl/umi_fifo_flex_arb.sv
// Round-robin, message-aware arbiter in front of a umi_fifo_flex input port.
// Once a requester's first beat of a multi-beat message is accepted, the grant
// stays with it until the beat carrying EOM (cmd[22]) is accepted. One output
// register stage sits between the arbiter and the FIFO.
//
// Ports:
//   clk, nreset                     clock, asynchronous active-low reset
//   umi_in_valid/ready [N]          per-requester handshake
//   umi_in_cmd/dstaddr/srcaddr/data requester i packed at [i*W +: W]
//   umi_in_mask [N]                 1 = excluded from new arbitration
//   umi_out_valid/ready             handshake towards the FIFO
//   umi_out_cmd/dstaddr/srcaddr/data registered payload
//   grant [N]                       one-hot current grant, 0 if none
//   locked                          1 while inside a message
module umi_fifo_flex_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 256,
  parameter int unsigned AW = 64,
  parameter int unsigned CW = 32
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  input  logic [N-1:0]    umi_in_mask,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready,
  output logic [N-1:0]    grant,
  output logic            locked
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PtrW-1:0] LastId = PtrW'(N - 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e          state_q;
  logic [PtrW-1:0] rr_ptr_q;
  logic [PtrW-1:0] lock_id_q;
  logic            out_full_q;

  logic [N-1:0]    cand;
  logic [PtrW-1:0] sel;
  logic            sel_vld;
  logic [PtrW-1:0] nxt_ptr;
  logic [CW-1:0]   sel_cmd;
  logic            space;
  logic            load;
  logic            eom;
  int unsigned     idx;

  always_comb begin
    cand    = umi_in_valid & ~umi_in_mask;
    sel     = lock_id_q;
    sel_vld = (state_q == StLocked);
    idx     = 0;
    if (state_q == StIdle) begin
      // First candidate at or after rr_ptr; explicit wrap so N need not be a power of two.
      for (int unsigned k = 0; k < N; k++) begin
        idx = 32'(rr_ptr_q) + k;
        if (idx >= N) idx = idx - N;
        if (!sel_vld && cand[idx[PtrW-1:0]]) begin
          sel_vld = 1'b1;
          sel     = idx[PtrW-1:0];
        end
      end
    end
  end

  always_comb begin
    space        = ~out_full_q | umi_out_ready;
    sel_cmd      = umi_in_cmd[32'(sel)*CW +: CW];
    eom          = sel_cmd[22];
    nxt_ptr      = (sel == LastId) ? '0 : sel + 1'b1;
    grant        = '0;
    umi_in_ready = '0;
    // Gating with nreset keeps grant/ready at 0 while reset is held.
    if (nreset && sel_vld) begin
      grant[sel]        = 1'b1;
      umi_in_ready[sel] = space;
    end
    load = |(umi_in_valid & umi_in_ready);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
    end else if (load) begin
      if (eom) begin
        state_q  <= StIdle;
        rr_ptr_q <= nxt_ptr;
      end else begin
        state_q   <= StLocked;
        lock_id_q <= sel;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_full_q      <= 1'b0;
      umi_out_cmd     <= '0;
      umi_out_dstaddr <= '0;
      umi_out_srcaddr <= '0;
      umi_out_data    <= '0;
    end else if (load) begin
      // A drain and a load in the same cycle replace the payload with no bubble.
      out_full_q      <= 1'b1;
      umi_out_cmd     <= sel_cmd;
      umi_out_dstaddr <= umi_in_dstaddr[32'(sel)*AW +: AW];
      umi_out_srcaddr <= umi_in_srcaddr[32'(sel)*AW +: AW];
      umi_out_data    <= umi_in_data[32'(sel)*DW +: DW];
    end else if (umi_out_ready) begin
      out_full_q <= 1'b0;
    end
  end

  assign umi_out_valid = out_full_q;
  assign locked        = (state_q == StLocked);

endmodule

// File: tb/tb_umi_fifo_flex_arb.sv
module tb_umi_fifo_flex_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            nreset = 1'b0;
  logic [N-1:0]    umi_in_valid = '0;
  logic [N*CW-1:0] umi_in_cmd = '0;
  logic [N*AW-1:0] umi_in_dstaddr = '0;
  logic [N*AW-1:0] umi_in_srcaddr = '0;
  logic [N*DW-1:0] umi_in_data = '0;
  logic [N-1:0]    umi_in_ready;
  logic [N-1:0]    umi_in_mask = '0;
  logic            umi_out_valid;
  logic [CW-1:0]   umi_out_cmd;
  logic [AW-1:0]   umi_out_dstaddr;
  logic [AW-1:0]   umi_out_srcaddr;
  logic [DW-1:0]   umi_out_data;
  logic            umi_out_ready = 1'b0;
  logic [N-1:0]    grant;
  logic            locked;

  always #5 clk = ~clk;

  umi_fifo_flex_arb #(.N(N), .DW(DW), .AW(AW), .CW(CW)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .umi_in_valid    (umi_in_valid),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (umi_in_ready),
    .umi_in_mask     (umi_in_mask),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_out_ready   (umi_out_ready),
    .grant           (grant),
    .locked          (locked)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;

  // Reference model: who holds the message lock (-1 = nobody), where the
  // round-robin search starts, and what the output register should hold.
  int            m_lock;
  int            m_ptr;
  bit            m_full;
  logic [CW-1:0] m_cmd;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_dst;
  logic [AW-1:0] m_src;
  logic [N-1:0]  e_grant;
  logic [N-1:0]  e_ready;
  int            e_g;
  bit            e_acc;
  int            acc_log[$];

  task automatic model_reset();
    m_lock = -1;
    m_ptr  = 0;
    m_full = 1'b0;
    m_cmd  = '0;
    m_data = '0;
    m_dst  = '0;
    m_src  = '0;
  endtask

  task automatic model_eval();
    bit space;
    space = !m_full || umi_out_ready;
    e_g = -1;
    if (nreset) begin
      if (m_lock >= 0) e_g = m_lock;
      else begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (e_g < 0 && umi_in_valid[idx] && !umi_in_mask[idx]) e_g = idx;
        end
      end
    end
    e_grant = (e_g >= 0) ? N'(1 << e_g) : '0;
    e_ready = space ? e_grant : '0;
    e_acc   = (e_g >= 0) && umi_in_valid[e_g] && space;
  endtask

  task automatic model_commit();
    if (e_acc) begin
      logic [CW-1:0] c;
      c      = umi_in_cmd[e_g*CW +: CW];
      m_full = 1'b1;
      m_cmd  = c;
      m_data = umi_in_data[e_g*DW +: DW];
      m_dst  = umi_in_dstaddr[e_g*AW +: AW];
      m_src  = umi_in_srcaddr[e_g*AW +: AW];
      acc_log.push_back(e_g);
      if (c[22]) begin
        m_lock = -1;
        m_ptr  = (e_g + 1) % N;
      end else begin
        m_lock = e_g;
      end
    end else if (umi_out_ready) begin
      m_full = 1'b0;
    end
  endtask

  task automatic at_negedge();
    @(negedge clk);
    model_eval();
    if (umi_out_valid && umi_out_ready) n_out++;
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] m, input logic [N-1:0] e,
                       input logic ordy);
    logic [CW-1:0] c;
    umi_in_valid  = v;
    umi_in_mask   = m;
    umi_out_ready = ordy;
    for (int i = 0; i < N; i++) begin
      c     = $urandom;
      c[22] = e[i];
      umi_in_cmd[i*CW +: CW]     = c;
      umi_in_data[i*DW +: DW]    = $urandom;
      umi_in_dstaddr[i*AW +: AW] = AW'($urandom);
      umi_in_srcaddr[i*AW +: AW] = AW'($urandom);
    end
  endtask

  task automatic test_reset();
    model_reset();
    nreset = 1'b0;
    drive('1, '0, '1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      at_negedge();
      n_cmp++;
      if ({grant, umi_in_ready, umi_out_valid, locked} !== {N'(0), N'(0), 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL reset_hold t=%0t: got grant=%b rdy=%b vld=%b lk=%b want all 0",
                 $time, grant, umi_in_ready, umi_out_valid, locked);
      end
      advance();
    end
    n_cmp++;
    if ({umi_out_cmd, umi_out_data, umi_out_dstaddr, umi_out_srcaddr} !== '0) begin
      n_err++;
      $display("FAIL reset_payload: got cmd=%h data=%h want 0", umi_out_cmd, umi_out_data);
    end
    nreset = 1'b1;
    drive('1, '0, '1, 1'b1);
    at_negedge();
    n_cmp++;
    if (grant !== N'(1) || grant !== e_grant) begin
      n_err++;
      $display("FAIL reset_first_grant: got %b want %b", grant, N'(1));
    end
    advance();
  endtask

  task automatic test_fairness();
    int p0;
    int s;
    p0 = m_ptr;
    s  = acc_log.size();
    for (int c = 0; c < 12; c++) begin
      drive('1, '0, '1, 1'b1);
      at_negedge();
      n_cmp++;
      if ({grant, umi_in_ready, umi_out_valid, locked} !== {e_grant, e_ready, m_full, m_lock >= 0}) begin
        n_err++;
        $display("FAIL fair_ctl t=%0t: got %b %b %b %b want %b %b %b %b", $time, grant,
                 umi_in_ready, umi_out_valid, locked, e_grant, e_ready, m_full, m_lock >= 0);
      end
      if (m_full) begin
        n_cmp++;
        if ({umi_out_cmd, umi_out_data, umi_out_dstaddr, umi_out_srcaddr} !== {m_cmd, m_data, m_dst, m_src}) begin
          n_err++;
          $display("FAIL fair_payload t=%0t: got cmd=%h data=%h want cmd=%h data=%h", $time,
                   umi_out_cmd, umi_out_data, m_cmd, m_data);
        end
      end
      advance();
    end
    n_cmp++;
    if (acc_log.size() - s != 12) begin
      n_err++;
      $display("FAIL fair_rate: got %0d beats want 12", acc_log.size() - s);
    end else begin
      for (int k = 0; k < 12; k++) begin
        n_cmp++;
        if (acc_log[s+k] != (p0 + k) % N) begin
          n_err++;
          $display("FAIL fair_order beat %0d: got req %0d want req %0d", k, acc_log[s+k], (p0 + k) % N);
        end
      end
    end
  endtask

  task automatic test_lock();
    int b;
    b = 0;
    drive(4'b0100, '0, 4'b1011, 1'b1);
    for (int c = 0; c < 20 && b < 3; c++) begin
      at_negedge();
      n_cmp++;
      if ({grant, umi_in_ready, umi_out_valid, locked} !== {e_grant, e_ready, m_full, m_lock >= 0}) begin
        n_err++;
        $display("FAIL lock_ctl t=%0t: got %b %b %b %b want %b %b %b %b", $time, grant,
                 umi_in_ready, umi_out_valid, locked, e_grant, e_ready, m_full, m_lock >= 0);
      end
      if (m_full) begin
        n_cmp++;
        if ({umi_out_cmd, umi_out_data, umi_out_dstaddr, umi_out_srcaddr} !== {m_cmd, m_data, m_dst, m_src}) begin
          n_err++;
          $display("FAIL lock_payload t=%0t: got cmd=%h want cmd=%h", $time, umi_out_cmd, m_cmd);
        end
      end
      if (e_acc && e_g == 2) b++;
      advance();
      drive({1'b1, b < 3, 1'b0, 1'b1}, '0, {1'b1, b == 2, 1'b1, 1'b1}, 1'b1);
    end
    n_cmp++;
    if (b != 3 || acc_log.size() < 3 || acc_log[$] != 2 || acc_log[$-1] != 2 || acc_log[$-2] != 2) begin
      n_err++;
      $display("FAIL lock_beats: got %0d beats from req 2 want 3 consecutive", b);
    end
    at_negedge();
    n_cmp++;
    if (grant !== 4'b1000) begin
      n_err++;
      $display("FAIL lock_next_grant: got %b want 1000", grant);
    end
    advance();
  endtask

  task automatic test_backpressure();
    int s;
    int o0;
    int f0;
    s  = acc_log.size();
    o0 = n_out;
    f0 = m_full ? 1 : 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 1)       drive('1, '0, '1, 1'b1);
      else if (c < 6)  drive('1, '0, N'($urandom), 1'b0);
      else if (c < 10) drive('1, '0, '1, 1'b1);
      else             drive('0, '0, '1, 1'b1);
      at_negedge();
      n_cmp++;
      if ({grant, umi_in_ready, umi_out_valid, locked} !== {e_grant, e_ready, m_full, m_lock >= 0}) begin
        n_err++;
        $display("FAIL bp_ctl t=%0t: got %b %b %b %b want %b %b %b %b", $time, grant,
                 umi_in_ready, umi_out_valid, locked, e_grant, e_ready, m_full, m_lock >= 0);
      end
      if (m_full) begin
        n_cmp++;
        if ({umi_out_cmd, umi_out_data, umi_out_dstaddr, umi_out_srcaddr} !== {m_cmd, m_data, m_dst, m_src}) begin
          n_err++;
          $display("FAIL bp_payload t=%0t: got cmd=%h data=%h want cmd=%h data=%h", $time,
                   umi_out_cmd, umi_out_data, m_cmd, m_data);
        end
      end
      if (c >= 1 && c < 6) begin
        n_cmp++;
        if (umi_in_ready !== '0) begin
          n_err++;
          $display("FAIL bp_ready t=%0t: got %b want 0000", $time, umi_in_ready);
        end
      end
      advance();
    end
    n_cmp++;
    if (n_out - o0 != acc_log.size() - s + f0) begin
      n_err++;
      $display("FAIL bp_count: got %0d outputs want %0d", n_out - o0, acc_log.size() - s + f0);
    end
  endtask

  task automatic test_mask();
    int b;
    for (int c = 0; c < 43; c++) begin
      if (c < 40) drive('1, 4'b0010, N'($urandom), $urandom_range(0, 3) != 0);
      else        drive('1, 4'b0010, '1, 1'b1);
      at_negedge();
      n_cmp++;
      if ({grant, umi_in_ready, umi_out_valid, locked} !== {e_grant, e_ready, m_full, m_lock >= 0}) begin
        n_err++;
        $display("FAIL mask_ctl t=%0t: got %b %b %b %b want %b %b %b %b", $time, grant,
                 umi_in_ready, umi_out_valid, locked, e_grant, e_ready, m_full, m_lock >= 0);
      end
      n_cmp++;
      if (grant[1] !== 1'b0) begin
        n_err++;
        $display("FAIL mask_excluded t=%0t: got grant=%b want bit1=0", $time, grant);
      end
      advance();
    end
    // Lock requester 1, then mask it mid-message.
    b = 0;
    drive(4'b0010, '0, 4'b0000, 1'b1);
    for (int c = 0; c < 20 && b < 3; c++) begin
      at_negedge();
      n_cmp++;
      if ({grant, umi_in_ready, umi_out_valid, locked} !== {e_grant, e_ready, m_full, m_lock >= 0}) begin
        n_err++;
        $display("FAIL mask_lock_ctl t=%0t: got %b %b %b %b want %b %b %b %b", $time, grant,
                 umi_in_ready, umi_out_valid, locked, e_grant, e_ready, m_full, m_lock >= 0);
      end
      if (e_acc && e_g == 1) b++;
      advance();
      drive({1'b1, 1'b1, b < 3, 1'b1}, 4'b0010, {1'b1, 1'b1, b == 2, 1'b1}, 1'b1);
    end
    n_cmp++;
    if (b != 3) begin
      n_err++;
      $display("FAIL mask_lock_complete: got %0d beats from req 1 want 3", b);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive(N'($urandom), N'($urandom & $urandom), N'($urandom), $urandom_range(0, 3) != 0);
      at_negedge();
      n_cmp++;
      if ({grant, umi_in_ready, umi_out_valid, locked} !== {e_grant, e_ready, m_full, m_lock >= 0}) begin
        n_err++;
        $display("FAIL rand_ctl t=%0t: got %b %b %b %b want %b %b %b %b", $time, grant,
                 umi_in_ready, umi_out_valid, locked, e_grant, e_ready, m_full, m_lock >= 0);
      end
      if (m_full) begin
        n_cmp++;
        if ({umi_out_cmd, umi_out_data, umi_out_dstaddr, umi_out_srcaddr} !== {m_cmd, m_data, m_dst, m_src}) begin
          n_err++;
          $display("FAIL rand_payload t=%0t: got cmd=%h data=%h want cmd=%h data=%h", $time,
                   umi_out_cmd, umi_out_data, m_cmd, m_data);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 5; c++) begin
      if (c < 3)       drive('1, '0, '1, 1'b1);
      else if (c == 3) drive(4'b0100, '0, 4'b0000, 1'b1);
      else             drive(4'b0100, '0, 4'b0000, 1'b0);
      at_negedge();
      n_cmp++;
      if ({grant, umi_in_ready, umi_out_valid, locked} !== {e_grant, e_ready, m_full, m_lock >= 0}) begin
        n_err++;
        $display("FAIL rstmid_pre t=%0t: got %b %b %b %b want %b %b %b %b", $time, grant,
                 umi_in_ready, umi_out_valid, locked, e_grant, e_ready, m_full, m_lock >= 0);
      end
      advance();
    end
    nreset = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({locked, umi_out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL rstmid_async: got locked=%b out_valid=%b want 0 0", locked, umi_out_valid);
    end
    for (int c = 0; c < 2; c++) begin
      drive('1, '0, '1, 1'b1);
      at_negedge();
      n_cmp++;
      if ({grant, umi_in_ready, umi_out_valid, locked} !== {e_grant, e_ready, m_full, m_lock >= 0}) begin
        n_err++;
        $display("FAIL rstmid_hold t=%0t: got %b %b %b %b want %b %b %b %b", $time, grant,
                 umi_in_ready, umi_out_valid, locked, e_grant, e_ready, m_full, m_lock >= 0);
      end
      advance();
    end
    nreset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive('1, '0, '1, 1'b1);
      at_negedge();
      if (c == 0) begin
        n_cmp++;
        if (grant !== N'(1)) begin
          n_err++;
          $display("FAIL rstmid_restart: got grant=%b want 0001", grant);
        end
      end
      n_cmp++;
      if ({grant, umi_in_ready, umi_out_valid, locked} !== {e_grant, e_ready, m_full, m_lock >= 0}) begin
        n_err++;
        $display("FAIL rstmid_post t=%0t: got %b %b %b %b want %b %b %b %b", $time, grant,
                 umi_in_ready, umi_out_valid, locked, e_grant, e_ready, m_full, m_lock >= 0);
      end
      advance();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fairness();
    test_lock();
    test_backpressure();
    test_mask();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
